data_memory_responder: RTL and testbench

Responder end of the memory-stage data-memory interface: a word-organised, byte-addressable RAM that services the load/store requests the memory stage issues each cycle. Reads are combinational with byte/halfword extraction and sign/zero extension; stores are merged into the addressed byte lanes on the rising edge. After reset, a zeroing sweep clears every word before `ready` rises. A sticky `fault` flag records misaligned or out-of-range accesses.

---
 rtl/data_memory_responder_pkg.sv | 38 +++
 rtl/data_memory_responder_if.sv | 42 ++++
 rtl/data_memory_responder_lane.sv | 83 ++++++++
 rtl/data_memory_responder.sv | 134 +++++++++++++
 tb/tb_data_memory_responder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_pkg
// Brief    : Shared types for the memory-stage data-memory responder.
// Revision : 1.0
// ============================================================================
package data_memory_responder_pkg;

    typedef logic [31:0] int_t;

    typedef enum logic [2:0] {
        READ_DISABLED = 3'd0,
        WORD          = 3'd1,
        BYTE_SIGNED   = 3'd2,
        BYTE_UNSIGNED = 3'd3,
        HALF_SIGNED   = 3'd4,
        HALF_UNSIGNED = 3'd5
    } extract_extend_t;

    typedef enum logic [1:0] {
        WRITE_DISABLED = 2'd0,
        WRITE_BYTE     = 2'd1,
        WRITE_HALF     = 2'd2,
        WRITE_WORD     = 2'd3
    } write_type_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_read_enabled(input extract_extend_t t);
        return (t == WORD) || (t == BYTE_SIGNED) || (t == BYTE_UNSIGNED) ||
               (t == HALF_SIGNED) || (t == HALF_UNSIGNED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder_if
// Brief    : Load/store request bus between the memory stage and the RAM.
// Revision : 1.0
// ============================================================================
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    int_t            address;
    extract_extend_t extract_extend_type;
    write_type_t     write_type;
    int_t            data_write;
    int_t            program_counter;
    int_t            data_read;
    logic            ready;
    logic            fault;

    modport master (
        output address,
        output extract_extend_type,
        output write_type,
        output data_write,
        output program_counter,
        input  data_read,
        input  ready,
        input  fault
    );

    modport slave (
        input  address,
        input  extract_extend_type,
        input  write_type,
        input  data_write,
        input  program_counter,
        output data_read,
        output ready,
        output fault
    );

endinterface
`default_nettype wire

// File: rtl/data_memory_responder_lane.sv
`default_nettype none
// ============================================================================
// Module   : memory_lane_unit
// Brief    : Byte-lane steering for stores and extract/extend for loads.
// Revision : 1.0
// ============================================================================
module memory_lane_unit
    import data_memory_responder_pkg::*;
(
    input  write_type_t     write_type_i,
    input  extract_extend_t extract_extend_type_i,
    input  logic [1:0]      byte_offset_i,
    input  int_t            data_write_i,
    input  int_t            stored_word_i,
    output logic [3:0]      byte_enable_o,
    output int_t            write_data_o,
    output int_t            read_data_o,
    output logic            write_misaligned_o,
    output logic            misaligned_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_read_misaligned;

    assign w_byte = stored_word_i[{byte_offset_i, 3'b000} +: 8];
    assign w_half = byte_offset_i[1] ? stored_word_i[31:16] : stored_word_i[15:0];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_enable_o      = 4'b0000;
        write_data_o       = '0;
        write_misaligned_o = 1'b0;
        case (write_type_i)
            WRITE_BYTE: begin
                byte_enable_o = 4'b0001 << byte_offset_i;
                write_data_o  = {4{data_write_i[7:0]}};
            end
            WRITE_HALF: begin
                byte_enable_o      = byte_offset_i[1] ? 4'b1100 : 4'b0011;
                write_data_o       = {2{data_write_i[15:0]}};
                write_misaligned_o = byte_offset_i[0];
            end
            WRITE_WORD: begin
                byte_enable_o      = 4'b1111;
                write_data_o       = data_write_i;
                write_misaligned_o = |byte_offset_i;
            end
            default: begin
                byte_enable_o = 4'b0000;
            end
        endcase
    end

    always_comb begin
        read_data_o       = '0;
        w_read_misaligned = 1'b0;
        case (extract_extend_type_i)
            WORD: begin
                read_data_o       = stored_word_i;
                w_read_misaligned = |byte_offset_i;
            end
            BYTE_SIGNED:   read_data_o = {{24{w_byte[7]}}, w_byte};
            BYTE_UNSIGNED: read_data_o = {24'd0, w_byte};
            HALF_SIGNED: begin
                read_data_o       = {{16{w_half[15]}}, w_half};
                w_read_misaligned = byte_offset_i[0];
            end
            HALF_UNSIGNED: begin
                read_data_o       = {16'd0, w_half};
                w_read_misaligned = byte_offset_i[0];
            end
            default: read_data_o = '0;
        endcase
        if (w_read_misaligned) begin
            read_data_o = '0;
        end
    end

    assign misaligned_o = w_read_misaligned | write_misaligned_o;

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Brief    : Word-organised byte-addressable data RAM with post-reset zeroing
//            sweep and sticky fault flag. Optional trace: DATA_MEMORY_TRACE_EN.
// Revision : 1.0
// ============================================================================
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int_t        ADDRESS_BASE = 32'h0000_0000
)(
    input  logic                     clock,
    input  logic                     reset,
    data_memory_responder_if.slave   bus
);

    localparam int unsigned INDEX_W = $clog2(DEPTH_WORDS);

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   sweep_index_q, sweep_index_d;
    logic                 fault_q, fault_d;
    int_t                 mem_q [DEPTH_WORDS];

    int_t                 w_offset;
    logic [INDEX_W-1:0]   w_word_index;
    logic                 w_in_range;
    logic                 w_run;
    logic                 w_read_en;
    logic                 w_write_en;
    int_t                 w_stored_word;
    logic [3:0]           w_byte_enable;
    int_t                 w_write_data;
    int_t                 w_lane_read;
    logic                 w_write_misaligned;
    logic                 w_misaligned;
    int_t                 w_merged_word;
    logic                 w_commit_write;
    logic                 w_access_fault;
    logic                 unused_pc;

    // Unsigned subtraction makes addresses below the base wrap high and fall out of range.
    assign w_offset      = bus.address - ADDRESS_BASE;
    assign w_word_index  = w_offset[INDEX_W+1:2];
    assign w_in_range    = (w_offset[31:2] < 30'(DEPTH_WORDS));
    assign w_run         = (state_q == RUN);
    assign w_read_en     = is_read_enabled(bus.extract_extend_type);
    assign w_write_en    = (bus.write_type != WRITE_DISABLED);
    assign w_stored_word = mem_q[w_word_index];
    assign unused_pc     = ^bus.program_counter;

    memory_lane_unit u_lane (
        .write_type_i          (bus.write_type),
        .extract_extend_type_i (bus.extract_extend_type),
        .byte_offset_i         (w_offset[1:0]),
        .data_write_i          (bus.data_write),
        .stored_word_i         (w_stored_word),
        .byte_enable_o         (w_byte_enable),
        .write_data_o          (w_write_data),
        .read_data_o           (w_lane_read),
        .write_misaligned_o    (w_write_misaligned),
        .misaligned_o          (w_misaligned)
    );

    for (genvar i = 0; i < 4; i++) begin : g_lane_merge
        assign w_merged_word[8*i +: 8] = w_byte_enable[i] ? w_write_data[8*i +: 8]
                                                          : w_stored_word[8*i +: 8];
    end

    assign w_commit_write = w_run && w_write_en && w_in_range && !w_write_misaligned;
    assign w_access_fault = ((w_read_en || w_write_en) && !w_in_range) || w_misaligned;

    assign bus.data_read = (w_run && w_in_range) ? w_lane_read : '0;
    assign bus.ready     = w_run;
    assign bus.fault     = fault_q;

    always_comb begin
        state_d       = state_q;
        sweep_index_d = sweep_index_q;
        fault_d       = fault_q;
        case (state_q)
            INIT: begin
                sweep_index_d = sweep_index_q + 1'b1;
                if (sweep_index_q == INDEX_W'(DEPTH_WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_access_fault) begin
                    fault_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= INIT;
            sweep_index_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_index_q <= sweep_index_d;
            fault_q       <= fault_d;
        end
    end

    // Contents are not reset directly; the INIT sweep that follows every reset clears them.
    always_ff @(posedge clock) begin
        if (state_q == INIT) begin
            mem_q[sweep_index_q] <= '0;
        end else if (w_commit_write) begin
            mem_q[w_word_index] <= w_merged_word;
        end
    end

`ifdef DATA_MEMORY_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset && w_commit_write) begin
            $display("[dmem] pc=%08h store addr=%08h type=%s word=%08h",
                     bus.program_counter, bus.address, bus.write_type.name(), w_merged_word);
        end
        if (!reset && w_run && w_access_fault) begin
            $display("[dmem] pc=%08h fault addr=%08h cause=%s",
                     bus.program_counter, bus.address,
                     w_in_range ? "misaligned" : "out of range");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Brief    : Scoreboard bench with a behavioural RAM model for the responder.
// Revision : 1.0
// ============================================================================
module tb_data_memory_responder;
    import data_memory_responder_pkg::*;

    localparam int   DEPTH = 16;
    localparam int_t BASE  = 32'h0000_1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_memory_responder_if bus ();

    data_memory_responder #(
        .DEPTH_WORDS  (DEPTH),
        .ADDRESS_BASE (BASE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int_t  rd;
        logic  flt;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_busy = 0;
    int_t model_mem [DEPTH];
    logic model_fault = 1'b0;
    int_t pc = 32'h0000_0400;

    task automatic chk(input string name, input int_t act, input int_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int rsize(input int rt);
        if (rt == 1) return 4;
        if (rt == 4 || rt == 5) return 2;
        return 1;
    endfunction

    function automatic int wsize(input int wt);
        if (wt == 3) return 4;
        if (wt == 2) return 2;
        return 1;
    endfunction

    function automatic bit in_rng(input int_t a);
        int_t off = a - BASE;
        return (off >> 2) < DEPTH;
    endfunction

    function automatic bit rd_on(input int rt);
        return rt >= 1 && rt <= 5;
    endfunction

    function automatic bit bad_access(input int_t a, input int rt, input int wt);
        bit bad = 0;
        if (rd_on(rt) && (!in_rng(a) || (a % rsize(rt)) != 0)) bad = 1;
        if (wt != 0 && (!in_rng(a) || (a % wsize(wt)) != 0)) bad = 1;
        return bad;
    endfunction

    function automatic int_t model_read(input int_t a, input int rt);
        int_t off = a - BASE;
        int_t w;
        int_t v;
        int   k = int'(a % 4);
        if (!rd_on(rt) || !in_rng(a) || (a % rsize(rt)) != 0) return 0;
        w = model_mem[off >> 2];
        case (rt)
            1: v = w;
            2, 3: begin
                v = (w >> (8 * k)) & 32'hFF;
                if (rt == 2 && v[7]) v = v | 32'hFFFF_FF00;
            end
            default: begin
                v = (w >> (8 * k)) & 32'hFFFF;
                if (rt == 4 && v[15]) v = v | 32'hFFFF_0000;
            end
        endcase
        return v;
    endfunction

    task automatic model_write(input int_t a, input int wt, input int_t wd);
        int_t off = a - BASE;
        int   k = int'(a % 4);
        if (wt == 0 || !in_rng(a) || (a % wsize(wt)) != 0) return;
        for (int i = 0; i < wsize(wt); i++) begin
            model_mem[off >> 2][8*(k+i) +: 8] = wd[8*i +: 8];
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic set_idle();
        bus.address             = BASE;
        bus.extract_extend_type = READ_DISABLED;
        bus.write_type          = WRITE_DISABLED;
        bus.data_write          = '0;
        bus.program_counter     = pc;
    endtask

    task automatic issue(input string name, input int_t a, input int rt, input int wt,
                         input int_t wd, input bit use_k, input int_t k);
        exp_t e;
        @(posedge clock); #1;
        bus.address             = a;
        bus.extract_extend_type = extract_extend_t'(rt[2:0]);
        bus.write_type          = write_type_t'(wt[1:0]);
        bus.data_write          = wd;
        bus.program_counter     = pc;
        pc = pc + 4;
        e.rd = use_k ? k : model_read(a, rt);
        if (bad_access(a, rt, wt)) model_fault = 1'b1;
        model_write(a, wt, wd);
        e.flt  = model_fault;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        @(posedge clock); #1;
        set_idle();
        while ((exp_q.size() > 0 || mon_busy) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int pulse_at);
        int cnt = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        set_idle();
        bus.extract_extend_type = WORD;
        @(posedge clock); #1;
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        chk("reset_fault", {31'd0, bus.fault}, 32'd0);
        chk("reset_data_read", bus.data_read, 32'd0);
        reset = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at) begin @(posedge clock); #1; end
            chk("midsweep_ready", {31'd0, bus.ready}, 32'd0);
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
        end
        bus.write_type = WRITE_WORD;
        bus.data_write = 32'hDEAD_BEEF;
        while (!bus.ready && cnt < 100) begin
            @(posedge clock); #1;
            cnt++;
            if (cnt == 5) chk("init_data_read", bus.data_read, 32'd0);
        end
        chk("sweep_length", cnt, DEPTH);
        set_idle();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_fault = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                mon_busy = 1;
                e = exp_q.pop_front();
                chk({e.name, "/data_read"}, bus.data_read, e.rd);
                @(posedge clock); #1;
                chk({e.name, "/fault"}, {31'd0, bus.fault}, {31'd0, e.flt});
                mon_busy = 0;
            end
        end
    end

    initial begin
        int_t a;
        int   rt, wt, al, off, sel;
        set_idle();
        do_reset(0);

        issue("rd_base",   BASE,     1, 0, 0,            1, 32'h0);
        issue("sw_word",   BASE + 4, 0, 3, 32'h8899AABB, 0, 0);
        issue("lb_signed", BASE + 5, 2, 0, 0,            1, 32'hFFFF_FFAA);
        issue("lb_unsign", BASE + 5, 3, 0, 0,            1, 32'h0000_00AA);
        issue("sh_half",   BASE + 6, 0, 2, 32'h1234,     0, 0);
        issue("lw_merged", BASE + 4, 1, 0, 0,            1, 32'h1234_AABB);
        issue("lh_signed", BASE + 4, 4, 0, 0,            1, 32'hFFFF_AABB);
        issue("rw_same",   BASE + 4, 1, 3, 32'hCAFEF00D, 1, 32'h1234_AABB);
        issue("rw_next",   BASE + 4, 1, 0, 0,            1, 32'hCAFE_F00D);
        issue("sw_misal",  BASE + 2, 0, 3, 32'hFFFFFFFF, 0, 0);
        issue("lw_unchg0", BASE,     1, 0, 0,            1, 32'h0);
        issue("lw_unchg4", BASE + 4, 1, 0, 0,            1, 32'hCAFE_F00D);
        issue("fault_sticky", BASE + 8, 3, 1, 32'h77,    0, 0);
        drain();
        do_reset(0);

        issue("sw_keep",   BASE + 8, 0, 3, 32'h11223344, 0, 0);
        issue("lw_keep",   BASE + 8, 1, 0, 0,            1, 32'h1122_3344);
        issue("rd_oor",    BASE + DEPTH * 4, 1, 0, 0,    1, 32'h0);
        drain();
        do_reset(7);

        issue("init_store_dropped", BASE,     1, 0, 0, 1, 32'h0);
        issue("run_reset_cleared",  BASE + 8, 1, 0, 0, 1, 32'h0);
        issue("rd_below_base",      BASE - 4, 1, 0, 0, 1, 32'h0);
        drain();
        do_reset(0);

        for (int i = 0; i < 150; i++) begin
            rt  = $urandom_range(0, 5);
            wt  = $urandom_range(0, 3);
            al  = (rsize(rt) > wsize(wt)) ? rsize(rt) : wsize(wt);
            off = $urandom_range(0, 3) & ~(al - 1);
            a   = BASE + $urandom_range(0, DEPTH - 1) * 4 + off;
            issue("rand_aligned", a, rt, wt, $urandom, 0, 0);
        end
        drain();

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = BASE + $urandom_range(0, DEPTH * 4 - 1);
            else if (sel == 8) a = BASE + DEPTH * 4 + $urandom_range(0, 15);
            else               a = BASE - $urandom_range(1, 16);
            issue("rand_any", a, $urandom_range(0, 5), $urandom_range(0, 3), $urandom, 0, 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
